binary_window_filter: RTL and testbench

Parametrised KxK window engine for the 1-bit image pipeline: streams a stored binarized frame out of a source BRAM in raster order, applies a selectable morphological or majority kernel, and writes the result into a destination BRAM. It generalises the single fixed averaging pass to configurable image size, kernel size, read latency and run-time mode. The top-level state machine can chain passes between frame buffer, BRAM1 and further buffers using the start/done handshake.

---
 rtl/binary_window_filter.sv | 185 ++++++++++++++++++
 tb/tb_binary_window_filter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/binary_window_filter.sv
// rtl/binary_window_filter.sv - KxK binary window engine: majority/erode/dilate/copy, BRAM to BRAM
// Optional ones counter output enabled by defining BINARY_WINDOW_FILTER_STATS_EN
module binary_window_filter #(
    parameter int WIDTH      = 480,
    parameter int HEIGHT     = 480,
    parameter int K          = 3,
    parameter int RD_LATENCY = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              start_in,
    input  logic [1:0]                        mode_in,
    input  logic [$clog2(K*K+1)-1:0]          thresh_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   rd_addr_out,
    output logic                              rd_en_out,
    input  logic                              rd_data_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   wr_addr_out,
    output logic                              wr_data_out,
    output logic                              wr_valid_out,
    output logic                              busy_out,
    output logic                              done_out
`ifdef BINARY_WINDOW_FILTER_STATS_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] ones_count_out
`endif
);

    localparam int R  = (K - 1) / 2;
    localparam int N  = WIDTH * HEIGHT;
    localparam int F  = R * WIDTH + R;
    localparam int D  = 2 * F;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(K * K + 1);
    localparam int QW = $clog2(N + F + 1);
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);

    localparam logic [QW-1:0] Q_N     = QW'(N);
    localparam logic [QW-1:0] Q_NF    = QW'(N + F);
    localparam logic [QW-1:0] Q_F     = QW'(F);
    localparam logic [QW-1:0] C_FLAST = QW'(F - 1);
    localparam logic [AW-1:0] A_LAST  = AW'(N - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [1:0]            r_mode;
    logic [CW-1:0]         r_thresh;
    logic [RD_LATENCY-1:0] r_rd_pipe;
    logic [D-1:0]          r_hist;
    logic [QW-1:0]         r_q;
    logic [QW-1:0]         r_cnt;
    logic [AW-1:0]         r_px;
    logic [XW-1:0]         r_cx;
    logic [YW-1:0]         r_cy;

    logic                  w_in_vld;
    logic                  w_step;
    logic                  w_in_bit;
    logic                  w_out_vld;
    logic [D:0]            w_line;
    logic [CW-1:0]         w_n;
    logic                  w_pix;

    // Stream index r_q covers the real pixels then F zero samples that push the last rows through.
    assign w_in_vld  = r_rd_pipe[RD_LATENCY-1];
    assign w_step    = (r_q < Q_N) ? w_in_vld : (r_q < Q_NF);
    assign w_in_bit  = (r_q < Q_N) ? rd_data_in : 1'b0;
    assign w_out_vld = w_step && (r_q >= Q_F);
    // w_line[d] is the sample d steps older than the newest one; the output center sits at d = F.
    assign w_line    = {r_hist, w_in_bit};

    always_comb begin
        w_n = '0;
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                if ((int'(r_cy) + dy >= 0) && (int'(r_cy) + dy < HEIGHT) &&
                    (int'(r_cx) + dx >= 0) && (int'(r_cx) + dx < WIDTH)) begin
                    w_n = w_n + CW'(w_line[(R - dy) * WIDTH + (R - dx)]);
                end
            end
        end
        case (r_mode)
            2'd0:    w_pix = (w_n >= r_thresh);
            2'd1:    w_pix = (w_n == CW'(K * K));
            2'd2:    w_pix = (w_n != '0);
            default: w_pix = w_line[F];
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_mode       <= '0;
            r_thresh     <= '0;
            r_rd_pipe    <= '0;
            r_hist       <= '0;
            r_q          <= '0;
            r_cnt        <= '0;
            r_px         <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            rd_addr_out  <= '0;
            rd_en_out    <= 1'b0;
            wr_addr_out  <= '0;
            wr_data_out  <= 1'b0;
            wr_valid_out <= 1'b0;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
`ifdef BINARY_WINDOW_FILTER_STATS_EN
            ones_count_out <= '0;
`endif
        end else begin
            r_rd_pipe[0] <= rd_en_out;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            if (w_step) begin
                r_hist <= {r_hist[D-2:0], w_in_bit};
                r_q    <= r_q + 1'b1;
            end

            wr_valid_out <= w_out_vld;
            wr_addr_out  <= w_out_vld ? r_px : '0;
            wr_data_out  <= w_out_vld & w_pix;
            if (w_out_vld) begin
                r_px <= r_px + 1'b1;
                if (r_cx == X_LAST) begin
                    r_cx <= '0;
                    r_cy <= r_cy + 1'b1;
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
`ifdef BINARY_WINDOW_FILTER_STATS_EN
                if (w_pix) ones_count_out <= ones_count_out + 1'b1;
`endif
            end

            done_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_mode      <= mode_in;
                        r_thresh    <= thresh_in;
                        r_state     <= S_READ;
                        busy_out    <= 1'b1;
                        rd_en_out   <= 1'b1;
                        rd_addr_out <= '0;
                        r_q         <= '0;
                        r_px        <= '0;
                        r_cx        <= '0;
                        r_cy        <= '0;
`ifdef BINARY_WINDOW_FILTER_STATS_EN
                        ones_count_out <= '0;
`endif
                    end
                end
                S_READ: begin
                    if (rd_addr_out == A_LAST) begin
                        rd_en_out   <= 1'b0;
                        rd_addr_out <= '0;
                        r_cnt       <= '0;
                        r_state     <= S_FLUSH;
                    end else begin
                        rd_addr_out <= rd_addr_out + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == C_FLAST) r_state <= S_DRAIN;
                    else                  r_cnt   <= r_cnt + 1'b1;
                end
                S_DRAIN: begin
                    if (wr_valid_out && (wr_addr_out == A_LAST)) begin
                        r_state  <= S_DONE;
                        done_out <= 1'b1;
                        busy_out <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_window_filter.sv
// tb/tb_binary_window_filter.sv - randomized bench for binary_window_filter against a pixel-level reference model
module tb_binary_window_filter;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int NP = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic       start    [2];
    logic [1:0] mode     [2];
    logic [3:0] th0;
    logic [4:0] th1;
    logic [4:0] rd_addr  [2];
    logic       rd_en    [2];
    logic       rd_data  [2];
    logic [4:0] wr_addr  [2];
    logic       wr_data  [2];
    logic       wr_valid [2];
    logic       busy     [2];
    logic       done     [2];
`ifdef BINARY_WINDOW_FILTER_STATS_EN
    logic [5:0] ones_cnt [2];
`endif
    logic       src [2][NP];
    logic       dst [2][NP];
    logic       d0a, d0b, d1a;
    int         n_chk  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    binary_window_filter #(.WIDTH(W), .HEIGHT(H), .K(3), .RD_LATENCY(2)) u_dut0 (
        .clk_in(clk), .rst_in(rst), .start_in(start[0]), .mode_in(mode[0]), .thresh_in(th0),
        .rd_addr_out(rd_addr[0]), .rd_en_out(rd_en[0]), .rd_data_in(rd_data[0]),
        .wr_addr_out(wr_addr[0]), .wr_data_out(wr_data[0]), .wr_valid_out(wr_valid[0]),
        .busy_out(busy[0]), .done_out(done[0])
`ifdef BINARY_WINDOW_FILTER_STATS_EN
        , .ones_count_out(ones_cnt[0])
`endif
    );

    binary_window_filter #(.WIDTH(W), .HEIGHT(H), .K(5), .RD_LATENCY(1)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .start_in(start[1]), .mode_in(mode[1]), .thresh_in(th1),
        .rd_addr_out(rd_addr[1]), .rd_en_out(rd_en[1]), .rd_data_in(rd_data[1]),
        .wr_addr_out(wr_addr[1]), .wr_data_out(wr_data[1]), .wr_valid_out(wr_valid[1]),
        .busy_out(busy[1]), .done_out(done[1])
`ifdef BINARY_WINDOW_FILTER_STATS_EN
        , .ones_count_out(ones_cnt[1])
`endif
    );

    // Source BRAMs: two-stage read for instance 0, one-stage for instance 1.
    always @(posedge clk) begin
        d0a <= rd_en[0] & src[0][rd_addr[0]];
        d0b <= d0a;
        d1a <= rd_en[1] & src[1][rd_addr[1]];
    end
    assign rd_data[0] = d0b;
    assign rd_data[1] = d1a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic ref_pix(input int s, input int x, input int y, input int md, input int th);
        int k, r, n;
        k = (s == 0) ? 3 : 5;
        r = k / 2;
        n = 0;
        for (int yy = y - r; yy <= y + r; yy++)
            for (int xx = x - r; xx <= x + r; xx++)
                if (yy >= 0 && yy < H && xx >= 0 && xx < W && src[s][yy*W+xx] === 1'b1) n++;
        case (md)
            0:       return (n >= th);
            1:       return (n == k * k);
            2:       return (n != 0);
            default: return src[s][y*W+x];
        endcase
    endfunction

    task automatic fill(input int s, input int kind);
        for (int i = 0; i < NP; i++) src[s][i] = (kind == 1) ? 1'b1 : (kind == 2) ? 1'($urandom) : 1'b0;
    endtask

    // Entered and left on a negedge; the cycle in which start is high is cycle 0.
    task automatic run_pass(input int s, input int md, input int th, input int exp_ones);
        int lat, f, nwr, ord_bad, lat_bad, busy_bad, done_at, bad, ones;
        logic e;
`ifdef BINARY_WINDOW_FILTER_STATS_EN
        logic [5:0] stat_done = '0;
`endif
        lat = (s == 0) ? 2 : 1;
        f   = (s == 0) ? 9 : 18;
        nwr = 0; ord_bad = 0; lat_bad = 0; busy_bad = 0; done_at = -1; bad = 0; ones = 0;
        for (int i = 0; i < NP; i++) dst[s][i] = 1'b0;
        mode[s] = 2'(md);
        if (s == 0) th0 = 4'(th); else th1 = 5'(th);
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
        mode[s]  = 2'($urandom);
        th0      = 4'($urandom);
        th1      = 5'($urandom);
        for (int c = 1; c < 300; c++) begin
            if (c == 10) start[s] = 1'b1;
            if (c == 11) start[s] = 1'b0;
            if (wr_valid[s] === 1'b1) begin
                if (int'(wr_addr[s]) != nwr) ord_bad++;
                if (c != 2 + lat + int'(wr_addr[s]) + f) lat_bad++;
                dst[s][wr_addr[s]] = wr_data[s];
                nwr++;
            end
            if (done[s] === 1'b1) begin
                done_at = c;
                if (busy[s] !== 1'b0) busy_bad++;
`ifdef BINARY_WINDOW_FILTER_STATS_EN
                stat_done = ones_cnt[s];
`endif
                @(negedge clk);
                break;
            end else if (busy[s] !== 1'b1) begin
                busy_bad++;
            end
            @(negedge clk);
        end
        check("done_cycle", done_at, 3 + lat + NP - 1 + f);
        check("write_count", nwr, NP);
        check("write_order", ord_bad, 0);
        check("write_latency", lat_bad, 0);
        check("busy", busy_bad, 0);
        check("done_pulse", {31'd0, done[s]}, 0);
        for (int p = 0; p < NP; p++) begin
            e = ref_pix(s, p % W, p / W, md, th);
            if (dst[s][p] !== e) bad++;
            if (dst[s][p] === 1'b1) ones++;
        end
        check("pixels", bad, 0);
        if (exp_ones >= 0) check("ones", ones, exp_ones);
`ifdef BINARY_WINDOW_FILTER_STATS_EN
        check("stat_at_done", {26'd0, stat_done}, ones);
        check("stat_held", {26'd0, ones_cnt[s]}, ones);
`endif
    endtask

    task automatic check_idle(input int s, input string tag);
        check(tag, {17'd0, rd_en[s], wr_valid[s], busy[s], done[s], rd_addr[s], wr_addr[s], wr_data[s]}, 0);
`ifdef BINARY_WINDOW_FILTER_STATS_EN
        check({tag, "_stat"}, {26'd0, ones_cnt[s]}, 0);
`endif
    endtask

    initial begin
        int md, th, nwr, ndone;
        rst = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        mode[0] = '0; mode[1] = '0;
        th0 = '0; th1 = '0;
        fill(0, 0); fill(1, 0);
        repeat (3) @(negedge clk);
        check_idle(0, "reset0");
        check_idle(1, "reset1");
        rst = 1'b0;
        @(negedge clk);

        fill(0, 1); run_pass(0, 0, 5, 28);
        run_pass(0, 1, 0, 12);
        fill(0, 0); src[0][2*W+3] = 1'b1; run_pass(0, 2, 0, 9);
        fill(0, 0); src[0][1*W+7] = 1'b1; run_pass(0, 2, 0, 6);
        check("no_row_wrap", {30'd0, dst[0][8], dst[0][16]}, 0);
        fill(0, 2); run_pass(0, 3, 0, -1);
        for (int rep = 0; rep < 4; rep++) begin
            fill(0, 2);
            md = $urandom_range(0, 3);
            th = $urandom_range(0, 9);
            run_pass(0, md, th, -1);
        end

        // Reset in cycle 20 of a pass.
        fill(0, 2);
        mode[0] = 2'd3; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle(0, "mid_reset");
        rst = 1'b0;
        nwr = 0; ndone = 0;
        repeat (60) begin
            @(negedge clk);
            if (wr_valid[0] !== 1'b0) nwr++;
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) ndone++;
        end
        check("writes_after_reset", nwr, 0);
        check("activity_after_reset", ndone, 0);
        run_pass(0, 3, 0, -1);

        fill(1, 2); run_pass(1, 3, 0, -1);
        fill(1, 1); run_pass(1, 1, 0, 0);
        fill(1, 0); src[1][1*W+4] = 1'b1; run_pass(1, 2, 0, 20);
        for (int rep = 0; rep < 4; rep++) begin
            fill(1, 2);
            md = $urandom_range(0, 3);
            th = $urandom_range(0, 25);
            run_pass(1, md, th, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
